// File: rtl/lsu_split_bus.sv
// lsu_split_bus: load/store unit between the core and a DATA_W-wide data bus.
// Accepts one access at a time. An access that crosses a bus-word boundary is
// split into two bus beats, and load results are sign- or zero-extended.
// Handles bus back-pressure, bus errors and a response timeout.
//
// Ports
//   clock, reset_n                 clock, asynchronous active-low reset
//   reqValid/reqReady              core request handshake (reqReady high only in IDLE)
//   is_read, addr, wdata           access type, byte address, LSB-aligned store data
//   data_size, is_mem_sign         log2 access bytes, sign-extend loads
//   respValid, respErr, rdata      one-cycle completion pulse, error flag, load data
//   io_reqValid/io_reqReady        bus request handshake
//   io_addr, io_wen, io_wdata      beat address, write enable, rotated store data
//   io_wmask, io_size              beat byte enables, beat size
//   io_respValid, io_respErr       bus response, bus error
//   io_rdata                       bus read data
module lsu_split_bus #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned MISALIGN_EN = 1,
    parameter int unsigned TIMEOUT     = 256
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                reqValid,
    output logic                reqReady,
    input  logic                is_read,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [1:0]          data_size,
    input  logic                is_mem_sign,
    output logic                respValid,
    output logic                respErr,
    output logic [DATA_W-1:0]   rdata,
    output logic                io_reqValid,
    input  logic                io_reqReady,
    output logic [ADDR_W-1:0]   io_addr,
    output logic                io_wen,
    output logic [DATA_W-1:0]   io_wdata,
    output logic [DATA_W/8-1:0] io_wmask,
    output logic [1:0]          io_size,
    input  logic                io_respValid,
    input  logic                io_respErr,
    input  logic [DATA_W-1:0]   io_rdata
);

    localparam int unsigned NB   = DATA_W / 8;
    localparam int unsigned OFFW = $clog2(NB);
    localparam int unsigned MW   = 2 * NB;
    localparam int unsigned TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_REQ1, ST_WAIT1, ST_REQ2, ST_WAIT2, ST_RESP
    } state_t;

    state_t              r_state, w_state_d;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [1:0]          r_size;
    logic                r_sign, r_is_read, r_split, r_err;
    logic [DATA_W-1:0]   r_beat0, r_beat1;
    logic [TW-1:0]       r_timer;

    logic                w_accept, w_in_split, w_in_err;
    logic                w_to_err, w_lat0, w_lat1, w_timeout;
    logic [OFFW-1:0]     w_off;
    logic [OFFW+2:0]     w_shamt;
    logic [3:0]          w_b;
    logic [6:0]          w_nbits;
    logic [MW-1:0]       w_bmask;
    logic [ADDR_W-1:0]   w_aligned;
    logic [DATA_W-1:0]   w_rsh, w_keep, w_top;
    logic                w_sbit;

    // True when off + (1 << sz) runs past the end of the bus word.
    function automatic logic f_split(input logic [OFFW-1:0] off, input logic [1:0] sz);
        return (32'(off) + (32'd1 << sz)) > NB;
    endfunction

    assign w_accept   = (r_state == ST_IDLE) && reqValid;
    assign w_in_split = f_split(addr[OFFW-1:0], data_size);
    assign w_in_err   = ((data_size == 2'd3) && (DATA_W == 32)) ||
                        (w_in_split && (MISALIGN_EN == 0));
    assign w_timeout  = (TIMEOUT != 0) && (r_timer == TLAST);

    // Next-state logic.
    always_comb begin
        w_state_d = r_state;
        w_to_err  = 1'b0;
        w_lat0    = 1'b0;
        w_lat1    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (reqValid) w_state_d = w_in_err ? ST_RESP : ST_REQ1;
            end
            ST_REQ1: begin
                if (io_reqReady) w_state_d = ST_WAIT1;
            end
            ST_WAIT1: begin
                if (io_respValid) begin
                    if (io_respErr) begin
                        w_state_d = ST_RESP;
                        w_to_err  = 1'b1;
                    end else begin
                        w_lat0    = 1'b1;
                        w_state_d = r_split ? ST_REQ2 : ST_RESP;
                    end
                end else if (w_timeout) begin
                    w_state_d = ST_RESP;
                    w_to_err  = 1'b1;
                end
            end
            ST_REQ2: begin
                if (io_reqReady) w_state_d = ST_WAIT2;
            end
            ST_WAIT2: begin
                if (io_respValid) begin
                    w_state_d = ST_RESP;
                    if (io_respErr) w_to_err = 1'b1;
                    else            w_lat1   = 1'b1;
                end else if (w_timeout) begin
                    w_state_d = ST_RESP;
                    w_to_err  = 1'b1;
                end
            end
            ST_RESP:  w_state_d = ST_IDLE;
            default:  w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_size    <= '0;
            r_sign    <= 1'b0;
            r_is_read <= 1'b0;
            r_split   <= 1'b0;
            r_err     <= 1'b0;
            r_beat0   <= '0;
            r_beat1   <= '0;
            r_timer   <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_addr    <= addr;
                r_wdata   <= wdata;
                r_size    <= data_size;
                r_sign    <= is_mem_sign;
                r_is_read <= is_read;
                r_split   <= w_in_split;
                r_err     <= w_in_err;
                r_beat0   <= '0;
                // Stays zero for single-beat loads so the upper half never leaks in.
                r_beat1   <= '0;
            end
            if (w_to_err) r_err   <= 1'b1;
            if (w_lat0)   r_beat0 <= io_rdata;
            if (w_lat1)   r_beat1 <= io_rdata;
            // Any state change clears the timer, which covers entry into each WAIT state.
            if (r_state != w_state_d) begin
                r_timer <= '0;
            end else if (r_state == ST_WAIT1 || r_state == ST_WAIT2) begin
                r_timer <= r_timer + TW'(1);
            end
        end
    end

    // Datapath derived from the latched request.
    assign w_off     = r_addr[OFFW-1:0];
    assign w_shamt   = {w_off, 3'b000};
    assign w_b       = 4'd1 << r_size;
    assign w_nbits   = {w_b, 3'b000};
    // Byte mask across two bus words: low half is beat 1, high half is beat 2.
    assign w_bmask   = ((MW'(1) << w_b) - MW'(1)) << w_off;
    assign w_aligned = r_addr & ~ADDR_W'(NB - 1);

    assign w_rsh  = DATA_W'({r_beat1, r_beat0} >> w_shamt);
    assign w_keep = (32'(w_nbits) >= DATA_W) ? '1 : ((DATA_W'(1) << w_nbits) - DATA_W'(1));
    assign w_top  = w_keep & ~(w_keep >> 1);
    assign w_sbit = r_sign & (|(w_rsh & w_top));

    always_comb begin
        reqReady    = (r_state == ST_IDLE);
        respValid   = (r_state == ST_RESP);
        respErr     = (r_state == ST_RESP) && r_err;
        rdata       = '0;
        io_reqValid = 1'b0;
        io_addr     = '0;
        io_wen      = 1'b0;
        io_wdata    = '0;
        io_wmask    = '0;
        io_size     = '0;
        if (r_state == ST_RESP && r_is_read && !r_err) begin
            rdata = (w_rsh & w_keep) | ({DATA_W{w_sbit}} & ~w_keep);
        end
        if (r_state == ST_REQ1 || r_state == ST_REQ2) begin
            io_reqValid = 1'b1;
            io_wen      = ~r_is_read;
            io_wdata    = DATA_W'(({r_wdata, r_wdata} << w_shamt) >> DATA_W);
            io_size     = r_split ? 2'(OFFW) : r_size;
            if (r_state == ST_REQ1) begin
                io_addr  = r_split ? w_aligned : r_addr;
                io_wmask = w_bmask[NB-1:0];
            end else begin
                io_addr  = w_aligned + ADDR_W'(NB);
                io_wmask = w_bmask[MW-1:NB];
            end
        end
    end

endmodule

// File: tb/tb_lsu_split_bus.sv
// Directed testbench for lsu_split_bus (DATA_W=32, TIMEOUT=16).
// A second instance with MISALIGN_EN=0 covers the misaligned-error path.
module tb_lsu_split_bus;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        reqValid = 1'b0, nm_reqValid = 1'b0;
    logic        is_read = 1'b0, is_mem_sign = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [1:0]  data_size = '0;
    logic        reqReady, respValid, respErr;
    logic [31:0] rdata;
    logic        io_reqValid, io_wen;
    logic        io_reqReady = 1'b1;
    logic [31:0] io_addr, io_wdata;
    logic [3:0]  io_wmask;
    logic [1:0]  io_size;
    logic        io_respValid = 1'b0, io_respErr = 1'b0;
    logic [31:0] io_rdata = '0;

    logic        nm_reqReady, nm_respValid, nm_respErr, nm_io_reqValid, nm_io_wen;
    logic [31:0] nm_rdata, nm_io_addr, nm_io_wdata;
    logic [3:0]  nm_io_wmask;
    logic [1:0]  nm_io_size;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    lsu_split_bus #(.DATA_W(32), .ADDR_W(32), .MISALIGN_EN(1), .TIMEOUT(16)) dut (
        .clock(clock), .reset_n(reset_n), .reqValid(reqValid), .reqReady(reqReady),
        .is_read(is_read), .addr(addr), .wdata(wdata), .data_size(data_size),
        .is_mem_sign(is_mem_sign), .respValid(respValid), .respErr(respErr), .rdata(rdata),
        .io_reqValid(io_reqValid), .io_reqReady(io_reqReady), .io_addr(io_addr),
        .io_wen(io_wen), .io_wdata(io_wdata), .io_wmask(io_wmask), .io_size(io_size),
        .io_respValid(io_respValid), .io_respErr(io_respErr), .io_rdata(io_rdata)
    );

    lsu_split_bus #(.DATA_W(32), .ADDR_W(32), .MISALIGN_EN(0), .TIMEOUT(16)) dut_nm (
        .clock(clock), .reset_n(reset_n), .reqValid(nm_reqValid), .reqReady(nm_reqReady),
        .is_read(is_read), .addr(addr), .wdata(wdata), .data_size(data_size),
        .is_mem_sign(is_mem_sign), .respValid(nm_respValid), .respErr(nm_respErr),
        .rdata(nm_rdata), .io_reqValid(nm_io_reqValid), .io_reqReady(1'b1),
        .io_addr(nm_io_addr), .io_wen(nm_io_wen), .io_wdata(nm_io_wdata),
        .io_wmask(nm_io_wmask), .io_size(nm_io_size), .io_respValid(1'b0),
        .io_respErr(1'b0), .io_rdata(32'h0)
    );

    // Bus responder: stalls io_reqReady for stall_left requesting cycles, logs each
    // accepted beat and answers it in the following cycle when resp_en allows.
    logic [31:0] beat_data [2];
    logic [1:0]  resp_en = 2'b11, resp_err_en = 2'b00;
    int          stall_left = 0;
    int          log_n = 0;
    logic [31:0] log_addr [4], log_wdata [4];
    logic [3:0]  log_mask [4];
    logic [1:0]  log_size [4];
    logic        log_wen [4];
    bit          pend = 1'b0;
    int          pend_beat = 0;
    logic        force_resp = 1'b0;

    always @(negedge clock) begin
        io_reqReady = (stall_left == 0);
        if (io_reqValid) begin
            if (io_reqReady) begin
                if (log_n < 4) begin
                    log_addr[log_n]  = io_addr;
                    log_wdata[log_n] = io_wdata;
                    log_mask[log_n]  = io_wmask;
                    log_size[log_n]  = io_size;
                    log_wen[log_n]   = io_wen;
                end
                pend_beat = (log_n > 1) ? 1 : log_n;
                log_n++;
                pend = 1'b1;
            end else begin
                stall_left--;
            end
        end
    end

    always @(posedge clock) begin
        #1;
        if (pend) begin
            io_respValid = resp_en[pend_beat];
            io_respErr   = resp_err_en[pend_beat];
            io_rdata     = beat_data[pend_beat];
            pend         = 1'b0;
        end else if (force_resp) begin
            io_respValid = 1'b1;
            io_respErr   = 1'b0;
            io_rdata     = 32'hCAFEF00D;
        end else begin
            io_respValid = 1'b0;
            io_respErr   = 1'b0;
            io_rdata     = '0;
        end
    end

    // Issues one access and waits (bounded) for the completion pulse.
    // lat counts negedges after the accepting edge; 0 means no completion.
    task automatic issue(input logic rd, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic sg, output int lat,
                         output int rv_cycles, output logic err, output logic [31:0] rdo);
        lat = 0; rv_cycles = 0; err = 1'b0; rdo = '0;
        log_n = 0;
        @(negedge clock);
        is_read = rd; addr = a; wdata = wd; data_size = sz; is_mem_sign = sg;
        reqValid = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clock);
            reqValid = 1'b0;
            if (io_reqValid) rv_cycles++;
            if (respValid) begin
                lat = k; err = respErr; rdo = rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        n_vec += 8;
        if (reqReady !== 1'b1) begin $display("FAIL reset reqReady: got %b want 1", reqReady); n_err++; end
        if (respValid !== 1'b0) begin $display("FAIL reset respValid: got %b want 0", respValid); n_err++; end
        if (respErr !== 1'b0) begin $display("FAIL reset respErr: got %b want 0", respErr); n_err++; end
        if (rdata !== 32'h0) begin $display("FAIL reset rdata: got %h want 0", rdata); n_err++; end
        if (io_reqValid !== 1'b0) begin $display("FAIL reset io_reqValid: got %b want 0", io_reqValid); n_err++; end
        if (io_wen !== 1'b0) begin $display("FAIL reset io_wen: got %b want 0", io_wen); n_err++; end
        if ({io_addr, io_wdata, io_wmask, io_size} !== 70'h0) begin
            $display("FAIL reset bus outputs: addr %h wdata %h mask %b size %0d want all 0",
                     io_addr, io_wdata, io_wmask, io_size);
            n_err++;
        end
        if (nm_reqReady !== 1'b1) begin $display("FAIL reset nm reqReady: got %b want 1", nm_reqReady); n_err++; end
        reset_n = 1'b1;
    endtask

    task automatic test_lw_aligned();
        int lat, rvc; logic err; logic [31:0] rd;
        beat_data[0] = 32'hDEADBEEF;
        issue(1'b1, 32'h100, 32'h0, 2'd2, 1'b0, lat, rvc, err, rd);
        n_vec += 6;
        if (lat !== 3) begin $display("FAIL lw_aligned latency: got %0d want 3", lat); n_err++; end
        if (rd !== 32'hDEADBEEF) begin $display("FAIL lw_aligned rdata: got %h want deadbeef", rd); n_err++; end
        if (err !== 1'b0) begin $display("FAIL lw_aligned respErr: got %b want 0", err); n_err++; end
        if (log_n !== 1) begin $display("FAIL lw_aligned beats: got %0d want 1", log_n); n_err++; end
        if (log_addr[0] !== 32'h100 || log_mask[0] !== 4'b1111) begin
            $display("FAIL lw_aligned beat: addr %h mask %b want 100 1111", log_addr[0], log_mask[0]);
            n_err++;
        end
        if (log_size[0] !== 2'd2 || log_wen[0] !== 1'b0) begin
            $display("FAIL lw_aligned size/wen: got %0d/%b want 2/0", log_size[0], log_wen[0]);
            n_err++;
        end
    endtask

    task automatic test_lw_split();
        int lat, rvc; logic err; logic [31:0] rd;
        beat_data[0] = 32'h44332211;
        beat_data[1] = 32'h88776655;
        issue(1'b1, 32'h103, 32'h0, 2'd2, 1'b0, lat, rvc, err, rd);
        n_vec += 6;
        if (lat !== 5) begin $display("FAIL lw_split latency: got %0d want 5", lat); n_err++; end
        if (rd !== 32'h77665544 || err !== 1'b0) begin
            $display("FAIL lw_split result: rdata %h err %b want 77665544 0", rd, err); n_err++;
        end
        if (log_n !== 2) begin $display("FAIL lw_split beats: got %0d want 2", log_n); n_err++; end
        if (log_addr[0] !== 32'h100 || log_addr[1] !== 32'h104) begin
            $display("FAIL lw_split addr: got %h %h want 100 104", log_addr[0], log_addr[1]); n_err++;
        end
        if (log_mask[0] !== 4'b1000 || log_mask[1] !== 4'b0111) begin
            $display("FAIL lw_split mask: got %b %b want 1000 0111", log_mask[0], log_mask[1]); n_err++;
        end
        if (log_size[0] !== 2'd2 || log_size[1] !== 2'd2) begin
            $display("FAIL lw_split size: got %0d %0d want 2 2", log_size[0], log_size[1]); n_err++;
        end
    endtask

    task automatic test_sh_split();
        int lat, rvc; logic err; logic [31:0] rd;
        beat_data[0] = 32'h11111111;
        beat_data[1] = 32'h22222222;
        issue(1'b0, 32'h003, 32'h0000ABCD, 2'd1, 1'b0, lat, rvc, err, rd);
        n_vec += 6;
        if (log_n !== 2) begin $display("FAIL sh_split beats: got %0d want 2", log_n); n_err++; end
        if (log_addr[0] !== 32'h0 || log_addr[1] !== 32'h4) begin
            $display("FAIL sh_split addr: got %h %h want 0 4", log_addr[0], log_addr[1]); n_err++;
        end
        if (log_mask[0] !== 4'b1000 || log_mask[1] !== 4'b0001) begin
            $display("FAIL sh_split mask: got %b %b want 1000 0001", log_mask[0], log_mask[1]); n_err++;
        end
        if (log_wdata[0] !== 32'hCD0000AB || log_wdata[1] !== 32'hCD0000AB) begin
            $display("FAIL sh_split wdata: got %h %h want cd0000ab", log_wdata[0], log_wdata[1]); n_err++;
        end
        if (log_wen[0] !== 1'b1 || log_wen[1] !== 1'b1) begin
            $display("FAIL sh_split wen: got %b %b want 1 1", log_wen[0], log_wen[1]); n_err++;
        end
        if (lat !== 5 || rd !== 32'h0 || err !== 1'b0) begin
            $display("FAIL sh_split resp: lat %0d rdata %h err %b want 5 0 0", lat, rd, err); n_err++;
        end
    endtask

    task automatic test_load_extend();
        int lat, rvc; logic err; logic [31:0] rd;
        beat_data[0] = 32'h00800000;
        issue(1'b1, 32'h102, 32'h0, 2'd0, 1'b1, lat, rvc, err, rd);
        n_vec += 3;
        if (rd !== 32'hFFFFFF80) begin $display("FAIL lb_signed rdata: got %h want ffffff80", rd); n_err++; end
        if (log_addr[0] !== 32'h102 || log_mask[0] !== 4'b0100 || log_size[0] !== 2'd0) begin
            $display("FAIL lb_signed beat: addr %h mask %b size %0d want 102 0100 0",
                     log_addr[0], log_mask[0], log_size[0]);
            n_err++;
        end
        if (lat !== 3) begin $display("FAIL lb_signed latency: got %0d want 3", lat); n_err++; end
        issue(1'b1, 32'h102, 32'h0, 2'd0, 1'b0, lat, rvc, err, rd);
        n_vec++;
        if (rd !== 32'h00000080) begin $display("FAIL lb_unsigned rdata: got %h want 00000080", rd); n_err++; end
        beat_data[0] = 32'h9ABC0000;
        issue(1'b1, 32'h002, 32'h0, 2'd1, 1'b1, lat, rvc, err, rd);
        n_vec += 2;
        if (rd !== 32'hFFFF9ABC) begin $display("FAIL lh_signed rdata: got %h want ffff9abc", rd); n_err++; end
        if (log_mask[0] !== 4'b1100) begin $display("FAIL lh_signed mask: got %b want 1100", log_mask[0]); n_err++; end
    endtask

    task automatic test_wrap_stall();
        int lat, rvc; logic err; logic [31:0] rd;
        beat_data[0] = 32'h12345678;
        beat_data[1] = 32'h9ABCDEF0;
        stall_left = 5;
        issue(1'b1, 32'hFFFFFFFE, 32'h0, 2'd2, 1'b0, lat, rvc, err, rd);
        n_vec += 6;
        if (log_addr[0] !== 32'hFFFFFFFC || log_addr[1] !== 32'h0) begin
            $display("FAIL wrap addr: got %h %h want fffffffc 00000000", log_addr[0], log_addr[1]); n_err++;
        end
        if (log_mask[0] !== 4'b1100 || log_mask[1] !== 4'b0011) begin
            $display("FAIL wrap mask: got %b %b want 1100 0011", log_mask[0], log_mask[1]); n_err++;
        end
        if (rd !== 32'hDEF01234 || err !== 1'b0) begin
            $display("FAIL wrap rdata: got %h err %b want def01234 0", rd, err); n_err++;
        end
        if (log_n !== 2) begin $display("FAIL stall beats: got %0d want 2", log_n); n_err++; end
        if (rvc !== 7) begin $display("FAIL stall io_reqValid cycles: got %0d want 7", rvc); n_err++; end
        if (lat !== 10) begin $display("FAIL stall latency: got %0d want 10", lat); n_err++; end
    endtask

    task automatic test_bus_err();
        int lat, rvc; logic err; logic [31:0] rd;
        resp_err_en = 2'b01;
        beat_data[0] = 32'h55555555;
        issue(1'b0, 32'h102, 32'h11223344, 2'd2, 1'b0, lat, rvc, err, rd);
        resp_err_en = 2'b00;
        n_vec += 3;
        if (err !== 1'b1 || rd !== 32'h0) begin
            $display("FAIL bus_err resp: err %b rdata %h want 1 0", err, rd); n_err++;
        end
        if (lat !== 3) begin $display("FAIL bus_err latency: got %0d want 3", lat); n_err++; end
        if (log_n !== 1) begin $display("FAIL bus_err beats: got %0d want 1", log_n); n_err++; end
    endtask

    task automatic test_timeout();
        int lat, rvc; logic err; logic [31:0] rd;
        logic bad;
        resp_en = 2'b00;
        issue(1'b1, 32'h200, 32'h0, 2'd2, 1'b0, lat, rvc, err, rd);
        resp_en = 2'b11;
        n_vec += 3;
        if (lat !== 18) begin $display("FAIL timeout latency: got %0d want 18", lat); n_err++; end
        if (err !== 1'b1 || rd !== 32'h0) begin
            $display("FAIL timeout resp: err %b rdata %h want 1 0", err, rd); n_err++;
        end
        if (log_n !== 1) begin $display("FAIL timeout beats: got %0d want 1", log_n); n_err++; end
        // A late bus response must not produce a completion or start anything.
        @(negedge clock);
        force_resp = 1'b1;
        @(negedge clock);
        force_resp = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (respValid !== 1'b0 || reqReady !== 1'b1 || io_reqValid !== 1'b0) bad = 1'b1;
            @(negedge clock);
        end
        n_vec++;
        if (bad !== 1'b0) begin $display("FAIL late_response ignored: got disturbed=%b want 0", bad); n_err++; end
    endtask

    task automatic test_misalign_off();
        @(negedge clock);
        is_read = 1'b1; addr = 32'h101; data_size = 2'd2; is_mem_sign = 1'b0;
        nm_reqValid = 1'b1;
        @(negedge clock);
        nm_reqValid = 1'b0;
        n_vec += 3;
        if (nm_respValid !== 1'b1 || nm_respErr !== 1'b1) begin
            $display("FAIL misalign_off resp at t1: valid %b err %b want 1 1", nm_respValid, nm_respErr);
            n_err++;
        end
        if (nm_io_reqValid !== 1'b0) begin
            $display("FAIL misalign_off io_reqValid: got %b want 0", nm_io_reqValid); n_err++;
        end
        @(negedge clock);
        if (nm_respValid !== 1'b0 || nm_reqReady !== 1'b1 || nm_io_reqValid !== 1'b0) begin
            $display("FAIL misalign_off after: valid %b ready %b io_req %b want 0 1 0",
                     nm_respValid, nm_reqReady, nm_io_reqValid);
            n_err++;
        end
    endtask

    task automatic test_reset_midop();
        int lat, rvc; logic err; logic [31:0] rd;
        logic seen;
        // Reset while holding a request on the bus: io_reqValid must drop at once.
        stall_left = 1000;
        log_n = 0;
        @(negedge clock);
        is_read = 1'b1; addr = 32'h100; data_size = 2'd2; reqValid = 1'b1;
        @(negedge clock);
        reqValid = 1'b0;
        @(negedge clock);
        n_vec += 2;
        if (io_reqValid !== 1'b1) begin $display("FAIL reset_req pre: io_reqValid %b want 1", io_reqValid); n_err++; end
        #2 reset_n = 1'b0;
        #1;
        if (io_reqValid !== 1'b0) begin $display("FAIL reset_req drop: io_reqValid %b want 0", io_reqValid); n_err++; end
        @(negedge clock);
        stall_left = 0;
        reset_n = 1'b1;
        // Reset while waiting for the second beat's response.
        resp_en = 2'b01;
        beat_data[0] = 32'h44332211;
        log_n = 0;
        @(negedge clock);
        is_read = 1'b1; addr = 32'h103; data_size = 2'd2; reqValid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            reqValid = 1'b0;
        end
        n_vec += 2;
        if (log_n !== 2 || reqReady !== 1'b0) begin
            $display("FAIL reset_wait2 pre: beats %0d reqReady %b want 2 0", log_n, reqReady); n_err++;
        end
        #2 reset_n = 1'b0;
        #1;
        if (reqReady !== 1'b1 || io_reqValid !== 1'b0) begin
            $display("FAIL reset_wait2 idle: reqReady %b io_reqValid %b want 1 0", reqReady, io_reqValid);
            n_err++;
        end
        @(negedge clock);
        reset_n = 1'b1;
        resp_en = 2'b11;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (respValid !== 1'b0) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin $display("FAIL reset_wait2 pulse: respValid seen %b want 0", seen); n_err++; end
        beat_data[0] = 32'h0BADCAFE;
        issue(1'b1, 32'h100, 32'h0, 2'd2, 1'b0, lat, rvc, err, rd);
        n_vec++;
        if (rd !== 32'h0BADCAFE || lat !== 3) begin
            $display("FAIL reset_recover: rdata %h lat %0d want 0badcafe 3", rd, lat); n_err++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_data[0] = '0;
        beat_data[1] = '0;
        test_reset();
        test_lw_aligned();
        test_lw_split();
        test_sh_split();
        test_load_extend();
        test_wrap_stall();
        test_bus_err();
        test_timeout();
        test_misalign_off();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
